// File: rtl/clock_pkg.sv
// Shared mode encodings and default timing constants for the clock mode controller.
package clock_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    localparam int HOLD_CYCLES_DEF   = 8;
    localparam int REPEAT_CYCLES_DEF = 4;
    localparam int BLINK_CYCLES_DEF  = 4;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button rising-edge detector with optional hold-to-repeat (macro CLOCK_AUTO_REPEAT_EN).
// A button already high when reset releases must be released before it can fire.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clr,
    output logic ev
);

    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("btn_repeat: HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
    end

    logic r_prev;
    logic r_armed;
    logic w_edge;

    assign w_edge = btn & ~r_prev & r_armed & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev <= btn;
            if (!btn) r_armed <= 1'b1;
        end
    end

`ifdef CLOCK_AUTO_REPEAT_EN
    localparam int CW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

    // r_cnt == 0 means idle; otherwise it counts cycles since the last event.
    logic [CW-1:0] r_cnt;
    logic          r_rep;
    logic [CW-1:0] w_limit;
    logic          w_rep_ev;

    assign w_limit  = r_rep ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES);
    assign w_rep_ev = btn & ~clr & (r_cnt != '0) & (r_cnt == w_limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_rep <= 1'b0;
        end else if (clr || !btn) begin
            r_cnt <= '0;
            r_rep <= 1'b0;
        end else if (w_edge) begin
            r_cnt <= CW'(1);
            r_rep <= 1'b0;
        end else if (w_rep_ev) begin
            r_cnt <= CW'(1);
            r_rep <= 1'b1;
        end else if (r_cnt != '0 && r_cnt != w_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ev = w_edge | w_rep_ev;
`else
    assign ev = w_edge;
`endif

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode FSM and field-increment sequencer for the seconds/minutes/hours counter chain.
// Auto-repeat of the increment button is enabled by macro CLOCK_AUTO_REPEAT_EN.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int BLINK_CYCLES  = BLINK_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              mode_btn,
    input  logic              inc_btn,
    input  logic              sec_wrap,
    input  logic              min_wrap,
    output logic              sec_en,
    output logic              min_en,
    output logic              hour_en,
    output logic              sec_clr,
    output logic [MODE_W-1:0] mode,
    output logic              blink
);

    localparam int BW = cnt_width(BLINK_CYCLES);

    mode_t         r_mode;
    mode_t         w_mode_nxt;
    logic          r_mbtn_prev;
    logic          r_mbtn_armed;
    logic          w_mode_edge;
    logic          w_inc_ev;
    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_cnt_nxt;
    logic          r_blink_ph;
    logic          w_blink_ph_nxt;
    logic          w_blink_nxt;
    logic          w_sec_en;
    logic          w_min_en;
    logic          w_hour_en;
    logic          w_sec_clr;

    assign w_mode_edge = mode_btn & ~r_mbtn_prev & r_mbtn_armed;

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_inc_btn (
        .clk (clk),
        .rst (rst),
        .btn (inc_btn),
        .clr (w_mode_edge),
        .ev  (w_inc_ev)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode       <= MODE_RUN;
            r_mbtn_prev  <= 1'b0;
            r_mbtn_armed <= 1'b0;
            r_blink_cnt  <= '0;
            r_blink_ph   <= 1'b0;
            sec_en       <= 1'b0;
            min_en       <= 1'b0;
            hour_en      <= 1'b0;
            sec_clr      <= 1'b0;
            blink        <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_mbtn_prev <= mode_btn;
            if (!mode_btn) r_mbtn_armed <= 1'b1;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_ph  <= w_blink_ph_nxt;
            sec_en      <= w_sec_en;
            min_en      <= w_min_en;
            hour_en     <= w_hour_en;
            sec_clr     <= w_sec_clr;
            blink       <= w_blink_nxt;
        end
    end

    always_comb begin
        w_mode_nxt      = r_mode;
        w_sec_en        = 1'b0;
        w_min_en        = 1'b0;
        w_hour_en       = 1'b0;
        w_sec_clr       = 1'b0;
        w_blink_cnt_nxt = '0;
        w_blink_ph_nxt  = 1'b0;
        w_blink_nxt     = 1'b0;

        if (w_mode_edge) begin
            case (r_mode)
                MODE_RUN:      w_mode_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: w_mode_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  w_mode_nxt = MODE_SET_SEC;
                default:       w_mode_nxt = MODE_RUN;
            endcase
        end

        // w_inc_ev is already suppressed by the inc block on a mode edge.
        case (r_mode)
            MODE_RUN: begin
                w_sec_en  = tick;
                w_min_en  = tick & sec_wrap;
                w_hour_en = tick & sec_wrap & min_wrap;
            end
            MODE_SET_HOUR: w_hour_en = w_inc_ev;
            MODE_SET_MIN:  w_min_en  = w_inc_ev;
            default:       w_sec_clr = w_inc_ev;
        endcase

        if (r_mode != MODE_RUN && !w_mode_edge) begin
            if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                w_blink_ph_nxt = ~r_blink_ph;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                w_blink_ph_nxt  = r_blink_ph;
            end
            w_blink_nxt = w_blink_ph_nxt & ~w_inc_ev;
        end
    end

    assign mode = r_mode;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: stimulus queues expected pulses, a monitor matches them.
module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic       sec_wrap;
    logic       min_wrap;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         at;
        logic [3:0] v;
    } exp_t;

    exp_t sb[$];

    clock_mode_ctrl #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .BLINK_CYCLES  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .sec_wrap (sec_wrap),
        .min_wrap (min_wrap),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hour_en  (hour_en),
        .sec_clr  (sec_clr),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse vector order: {sec_en, min_en, hour_en, sec_clr}
    always @(negedge clk) begin
        logic [3:0] got;
        exp_t       e;
        got = {sec_en, min_en, hour_en, sec_clr};
        if (rst === 1'b1 && got !== 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required no pulse", got, cyc);
            end else begin
                e = sb.pop_front();
                if (e.v !== got || e.at != cyc) begin
                    errors++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             got, cyc, e.v, e.at);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int at, input logic [3:0] v);
        exp_t e;
        e.at = at;
        e.v  = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    initial begin
        int c;
        rst      = 1'b0;
        tick     = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        sec_wrap = 1'b0;
        min_wrap = 1'b0;
        step(3);
        chk("reset_mode", int'(mode), 0);
        chk("reset_blink", int'(blink), 0);
        chk("reset_pulses", int'({sec_en, min_en, hour_en, sec_clr}), 0);
        rst = 1'b1;
        step(2);

        // RUN carry chain
        tick = 1'b1; sec_wrap = 1'b1; min_wrap = 1'b1;
        push(cyc + 1, 4'b1110);
        step();
        tick = 1'b0; sec_wrap = 1'b0; min_wrap = 1'b0;
        step();
        tick = 1'b1;
        push(cyc + 1, 4'b1000);
        step();
        tick = 1'b0;
        step();
        tick = 1'b1; sec_wrap = 1'b1;
        push(cyc + 1, 4'b1100);
        step();
        tick = 1'b0; sec_wrap = 1'b0;
        step();
        tick = 1'b1; min_wrap = 1'b1;
        push(cyc + 1, 4'b1000);
        step();
        tick = 1'b0; min_wrap = 1'b0;
        step();

        // Mode walk; the first press carries a tick that RUN must still honour
        mode_btn = 1'b1; tick = 1'b1;
        push(cyc + 1, 4'b1000);
        step();
        tick = 1'b0;
        chk("walk_mode_1", int'(mode), 1);
        mode_btn = 1'b0;
        step();
        for (int i = 2; i <= 4; i++) begin
            mode_btn = 1'b1;
            step();
            chk("walk_mode", int'(mode), i % 4);
            mode_btn = 1'b0;
            step();
        end

        // Held mode_btn advances once; blink phase checked while held, ticks ignored
        mode_btn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("blink_phase", int'(blink), ((k - 1) / 4) % 2);
            tick = (k % 3 == 0);
        end
        tick = 1'b0;
        chk("held_mode", int'(mode), 1);
        mode_btn = 1'b0;
        step();

        // SET_HOUR single press of 3 cycles
        inc_btn = 1'b1;
        push(cyc + 1, 4'b0010);
        step(3);
        inc_btn = 1'b0;
        step(2);

        // Mode edge and inc edge together: mode wins, inc dropped
        mode_btn = 1'b1; inc_btn = 1'b1;
        step();
        chk("conflict_mode", int'(mode), 2);
        chk("conflict_blink", int'(blink), 0);
        mode_btn = 1'b0; inc_btn = 1'b0;
        step(5);

        // SET_MIN hold: blink phase is high here, so a zero proves the inc override
        c = cyc;
        inc_btn = 1'b1;
        push(c + 1, 4'b0100);
`ifdef CLOCK_AUTO_REPEAT_EN
        push(c + 9, 4'b0100);
        push(c + 13, 4'b0100);
        push(c + 17, 4'b0100);
        push(c + 21, 4'b0100);
`endif
        step();
        chk("blink_forced_on_inc", int'(blink), 0);
        step();
        chk("blink_resumes", int'(blink), 1);
        step(19);
        inc_btn = 1'b0;
        step(3);

        // SET_SEC: inc clears seconds; simultaneous tick is dropped
        press_mode();
        chk("mode_set_sec", int'(mode), 3);
        tick = 1'b1; inc_btn = 1'b1;
        push(cyc + 1, 4'b0001);
        step();
        tick = 1'b0;
        step();
        inc_btn = 1'b0;
        step(2);
        press_mode();
        chk("mode_back_run", int'(mode), 0);

        // Reset mid-operation in SET_MIN with inc held
        press_mode();
        press_mode();
        chk("mode_set_min", int'(mode), 2);
        inc_btn = 1'b1;
        push(cyc + 1, 4'b0100);
        step(3);
        rst = 1'b0;
        #1;
        chk("async_reset_mode", int'(mode), 0);
        chk("async_reset_pulses", int'({sec_en, min_en, hour_en, sec_clr, blink}), 0);
        step(2);
        rst = 1'b1;
        step(3);
        chk("post_reset_mode", int'(mode), 0);
        press_mode();
        chk("post_reset_set_hour", int'(mode), 1);
        step(12);
        inc_btn = 1'b0;
        step();
        inc_btn = 1'b1;
        push(cyc + 1, 4'b0010);
        step();
        inc_btn = 1'b0;
        step(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d unmatched, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
